// File: rtl/reg_file_param.sv
// reg_file_param: DEPTH x DATA_W register file, one write and two read ports, plus a hardware clear sweep.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data onto matching read ports.
module reg_file_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [DATA_W-1:0] IN,
  input  logic [ADDR_W-1:0] INADDRESS,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] OUT1ADDRESS,
  input  logic [ADDR_W-1:0] OUT2ADDRESS,
  output logic [DATA_W-1:0] OUT1,
  output logic [DATA_W-1:0] OUT2,
  input  logic              CLEAR,
  output logic              BUSY
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;
  logic              busy_reg, busy_next;
  logic              wr_accept;
  logic              sweeping;
  logic [DEPTH-1:0][DATA_W-1:0] mem_flat;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      busy_reg  <= busy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    busy_next  = busy_reg;
    case (state_reg)
      ST_IDLE: begin
        if (CLEAR) begin
          state_next = ST_SWEEP;
          cnt_next   = '0;
          busy_next  = 1'b1;
        end
      end
      ST_SWEEP: begin
        // Counter wraps back to 0 on the final sweep edge.
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == LAST_IDX) begin
          state_next = ST_IDLE;
          busy_next  = 1'b0;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
        busy_next  = 1'b0;
      end
    endcase
  end

  assign sweeping  = (state_reg == ST_SWEEP);
  assign wr_accept = !sweeping && WRITE && !(ZERO_REG && (INADDRESS == '0));

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
      logic [DATA_W-1:0] q_reg;

      always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
          q_reg <= '0;
        end else if (sweeping && (cnt_reg == IDX)) begin
          q_reg <= '0;
        end else if (wr_accept && (INADDRESS == IDX)) begin
          q_reg <= IN;
        end
      end

      assign mem_flat[gi] = q_reg;
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;

      assign addr = (gi == 0) ? OUT1ADDRESS : OUT2ADDRESS;

      always_comb begin
        data = mem_flat[addr];
`ifdef REGFILE_BYPASS_EN
        // Only accepted writes are forwarded; sweep zeroing never is.
        if (RESET_N && WRITE && !busy_reg && (INADDRESS == addr)) begin
          data = IN;
        end
`endif
        if (ZERO_REG && (addr == '0)) begin
          data = '0;
        end
      end
    end
  endgenerate

  assign OUT1 = g_port[0].data;
  assign OUT2 = g_port[1].data;
  assign BUSY = busy_reg;

endmodule

// File: tb/tb_reg_file_param.sv
// Scoreboard bench for reg_file_param: two instances (ZERO_REG=0 and ZERO_REG=1) share stimulus
// and are checked against an array-based reference model; honours REGFILE_BYPASS_EN.
module tb_reg_file_param;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              CLK = 1'b0;
  logic              RESET_N = 1'b0;
  logic [DATA_W-1:0] IN = '0;
  logic [ADDR_W-1:0] INADDRESS = '0;
  logic              WRITE = 1'b0;
  logic [ADDR_W-1:0] OUT1ADDRESS = '0;
  logic [ADDR_W-1:0] OUT2ADDRESS = '0;
  logic              CLEAR = 1'b0;
  logic [DATA_W-1:0] out1_a, out2_a, out1_z, out2_z;
  logic              busy_a, busy_z;

  reg_file_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1'b0)) dut_a (
    .CLK(CLK), .RESET_N(RESET_N), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
    .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS), .OUT1(out1_a), .OUT2(out2_a),
    .CLEAR(CLEAR), .BUSY(busy_a));

  reg_file_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1'b1)) dut_z (
    .CLK(CLK), .RESET_N(RESET_N), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
    .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS), .OUT1(out1_z), .OUT2(out2_z),
    .CLEAR(CLEAR), .BUSY(busy_z));

  always #5 CLK = ~CLK;

  typedef struct {
    logic [DATA_W-1:0] o1;
    logic [DATA_W-1:0] o2;
    logic [DATA_W-1:0] z1;
    logic [DATA_W-1:0] z2;
    logic              busy;
    string             tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: plain array plus the index of the next entry to sweep (-1 when idle).
  logic [DATA_W-1:0] m [DEPTH];
  int                sweep_pos = -1;

  function automatic logic [DATA_W-1:0] model_rd(input logic [ADDR_W-1:0] a, input bit zr);
    if (zr && a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (RESET_N && WRITE && sweep_pos < 0 && a == INADDRESS) return IN;
`endif
    return m[a];
  endfunction

  task automatic model_zero();
    for (int i = 0; i < DEPTH; i++) m[i] = '0;
    sweep_pos = -1;
  endtask

  task automatic model_edge();
    if (!RESET_N) begin
      model_zero();
    end else if (sweep_pos >= 0) begin
      m[sweep_pos] = '0;
      sweep_pos++;
      if (sweep_pos == DEPTH) sweep_pos = -1;
    end else begin
      if (WRITE) m[INADDRESS] = IN;
      if (CLEAR) sweep_pos = 0;
    end
  endtask

  task automatic expect_now(input string tag);
    exp_t e;
    e.o1   = model_rd(OUT1ADDRESS, 1'b0);
    e.o2   = model_rd(OUT2ADDRESS, 1'b0);
    e.z1   = model_rd(OUT1ADDRESS, 1'b1);
    e.z2   = model_rd(OUT2ADDRESS, 1'b1);
    e.busy = (sweep_pos >= 0);
    e.tag  = tag;
    exp_q.push_back(e);
  endtask

  task automatic cycle(input logic wr, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                       input logic clr, input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2,
                       input string tag);
    WRITE = wr; INADDRESS = wa; IN = wd; CLEAR = clr;
    OUT1ADDRESS = a1; OUT2ADDRESS = a2;
    expect_now(tag);
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  // Reset asserted between edges; the first check lands before any further rising edge.
  task automatic async_reset(input string tag);
    WRITE = 1'b0; CLEAR = 1'b0; RESET_N = 1'b0;
    model_zero();
    expect_now(tag);
    @(posedge CLK); #1;
    expect_now({tag, "_hold"});
    @(posedge CLK); #1;
    RESET_N = 1'b1;
  endtask

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: compares every pending expectation at the falling edge.
  always @(negedge CLK) begin
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check({mon_e.tag, ".out1"},   out1_a, mon_e.o1);
      check({mon_e.tag, ".out2"},   out2_a, mon_e.o2);
      check({mon_e.tag, ".z_out1"}, out1_z, mon_e.z1);
      check({mon_e.tag, ".z_out2"}, out2_z, mon_e.z2);
      check({mon_e.tag, ".busy"},   {{(DATA_W-1){1'b0}}, busy_a}, {{(DATA_W-1){1'b0}}, mon_e.busy});
      check({mon_e.tag, ".z_busy"}, {{(DATA_W-1){1'b0}}, busy_z}, {{(DATA_W-1){1'b0}}, mon_e.busy});
      $display("txn %s a1=%0d a2=%0d out=%h/%h zout=%h/%h busy=%b", mon_e.tag,
               OUT1ADDRESS, OUT2ADDRESS, out1_a, out2_a, out1_z, out2_z, busy_a);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got %0d checks expected completion", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    model_zero();
    @(posedge CLK); #1;
    expect_now("por");
    @(posedge CLK); #1;
    RESET_N = 1'b1;

    // Basic writes, then reset without a clock edge.
    cycle(1'b1, 3'd3, 8'hA5, 1'b0, 3'd3, 3'd7, "wr_r3");
    cycle(1'b1, 3'd7, 8'h3C, 1'b0, 3'd3, 3'd7, "wr_r7");
    cycle(1'b0, 3'd0, 8'h00, 1'b0, 3'd3, 3'd7, "rd_3_7");
    async_reset("rst_async");

    // Fill, clear sweep, writes dropped while busy, first accepted write right after.
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b1, ADDR_W'(i), DATA_W'((i + 1) * 8'h11), 1'b0, 3'd2, ADDR_W'(i), "fill");
    cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 3'd0, "clear");
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b1, 3'd5, 8'hFF, 1'b1, 3'd2, 3'd5, "sweep_wr");
    cycle(1'b1, 3'd5, 8'hFF, 1'b0, 3'd2, 3'd5, "post_wr");
    cycle(1'b0, 3'd0, 8'h00, 1'b0, 3'd5, 3'd2, "post_rd");

    // Simultaneous write and clear.
    cycle(1'b1, 3'd1, 8'h42, 1'b1, 3'd1, 3'd5, "wr_clr");
    for (int i = 0; i < DEPTH + 1; i++)
      cycle(1'b0, 3'd0, 8'h00, 1'b0, 3'd1, 3'd5, "wr_clr_sweep");

    // Reset in the 4th sweep cycle, then a full sweep.
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b1, ADDR_W'(i), DATA_W'(8'hF0 | i), 1'b0, 3'd5, 3'd6, "refill");
    cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 3'd6, "clear2");
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 3'd0, 8'h00, 1'b0, 3'd5, 3'd6, "sweep2");
    async_reset("rst_mid_sweep");
    cycle(1'b1, 3'd7, 8'h5D, 1'b0, 3'd7, 3'd6, "wr_after_rst");
    cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd7, 3'd6, "clear3");
    for (int i = 0; i < DEPTH + 1; i++)
      cycle(1'b0, 3'd0, 8'h00, 1'b0, 3'd7, 3'd6, "sweep3");

    // Zero register and bypass.
    cycle(1'b1, 3'd0, 8'h77, 1'b0, 3'd0, 3'd0, "wr_r0");
    cycle(1'b1, 3'd6, 8'h55, 1'b0, 3'd0, 3'd6, "rd_r0");
    cycle(1'b1, 3'd6, 8'h9A, 1'b0, 3'd0, 3'd6, "bypass_r6");
    cycle(1'b1, 3'd0, 8'h31, 1'b0, 3'd0, 3'd6, "bypass_r0");
    cycle(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd6, "after_bypass");

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        async_reset("rnd_rst");
      end else begin
        cycle(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, DEPTH - 1)),
              DATA_W'($urandom), 1'($urandom_range(0, 15) == 0),
              ADDR_W'($urandom_range(0, DEPTH - 1)), ADDR_W'($urandom_range(0, DEPTH - 1)), "rnd");
      end
    end

    WRITE = 1'b0; CLEAR = 1'b0;
    @(negedge CLK); #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
